// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: groups the EX/MEM request, DM and MEM/WB signals of the
// MEM-stage load/store unit. slave = the unit, master = pipeline + data memory.
interface mem_access_unit_if;
  // EX/MEM request
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        stall;
  // data memory port
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_wren;
  logic [31:0] dm_rdata;
  // MEM/WB result and fault report
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_rd, dm_rdata,
    output stall, dm_addr, dm_wdata, dm_wren,
    output wb_valid, wb_data, wb_rd, fault, fault_cause, fault_addr
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rd, dm_rdata,
    input  stall, dm_addr, dm_wdata, dm_wren,
    input  wb_valid, wb_data, wb_rd, fault, fault_cause, fault_addr
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit in front of a word-wide data memory.
// Loads are lane-extracted and sign/zero-extended into registered writeback
// outputs; sub-word stores are done as a two-cycle read-modify-write.
// Optional feature macro: MAU_RANGE_CHECK_EN (fault on addresses >= 2**DM_AW).
module mem_access_unit #(
  parameter int unsigned DM_AW = 10
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;

`ifdef MAU_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  typedef enum logic [0:0] {IDLE, RMW_WR} state_t;

  state_t      state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] addr_q, addr_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  logic        stall_c;
  logic        dm_wren_c;
  logic [31:0] dm_addr_c;
  logic [31:0] dm_wdata_c;

  logic [1:0]  lane;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic        is_word;
  logic        is_half;
  logic        is_store;
  logic        misaligned;
  logic        out_of_range;
  logic [31:0] aligned_addr;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Request decode: size, alignment, range, lane extraction and store merge
  always_comb begin
    lane         = bus.req_addr[1:0];
    byte_sh      = {lane, 3'b000};
    half_sh      = {bus.req_addr[1], 4'b0000};
    is_word      = (bus.req_op == OP_LW) || (bus.req_op == OP_SW);
    is_half      = (bus.req_op == OP_LH) || (bus.req_op == OP_LHU) ||
                   (bus.req_op == OP_SH);
    is_store     = (bus.req_op == OP_SW) || (bus.req_op == OP_SH) ||
                   (bus.req_op == OP_SB);
    misaligned   = (is_word && (lane != 2'b00)) || (is_half && bus.req_addr[0]);
    out_of_range = RANGE_CHECK && ((bus.req_addr >> DM_AW) != 32'd0);
    aligned_addr = {bus.req_addr[31:2], 2'b00};
    byte_sel     = 8'(bus.dm_rdata >> byte_sh);
    half_sel     = 16'(bus.dm_rdata >> half_sh);

    case (bus.req_op)
      OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_ext = {16'h0000, half_sel};
      OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_ext = {24'h000000, byte_sel};
      default: load_ext = bus.dm_rdata;
    endcase

    if (bus.req_op == OP_SB) begin
      merged = (bus.dm_rdata & ~(32'h0000_00FF << byte_sh)) |
               (32'(bus.req_wdata[7:0]) << byte_sh);
    end else begin
      merged = (bus.dm_rdata & ~(32'h0000_FFFF << half_sh)) |
               (32'(bus.req_wdata[15:0]) << half_sh);
    end
  end

  // Next-state, next register values and combinational DM/stall outputs
  always_comb begin
    state_d      = state_q;
    merge_d      = merge_q;
    addr_d       = addr_q;
    wb_valid_d   = 1'b0;
    wb_data_d    = wb_data_q;
    wb_rd_d      = wb_rd_q;
    fault_d      = 1'b0;
    cause_d      = cause_q;
    fault_addr_d = fault_addr_q;
    stall_c      = 1'b0;
    dm_wren_c    = 1'b0;
    dm_addr_c    = aligned_addr;
    dm_wdata_c   = bus.req_wdata;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (misaligned || out_of_range) begin
            fault_d      = 1'b1;
            cause_d      = misaligned ? CAUSE_MISALIGN : CAUSE_RANGE;
            fault_addr_d = bus.req_addr;
          end else if (!is_store) begin
            wb_valid_d = (bus.req_rd != 5'd0);
            wb_rd_d    = bus.req_rd;
            wb_data_d  = load_ext;
          end else if (is_word) begin
            dm_wren_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            merge_d = merged;
            addr_d  = aligned_addr;
            state_d = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        dm_addr_c  = addr_q;
        dm_wdata_c = merge_q;
        dm_wren_c  = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // reset must block a pending RMW write immediately, not at the next edge
    if (!rst) begin
      dm_wren_c = 1'b0;
      stall_c   = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      merge_q      <= 32'd0;
      addr_q       <= 32'd0;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= 32'd0;
      wb_rd_q      <= 5'd0;
      fault_q      <= 1'b0;
      cause_q      <= 2'b00;
      fault_addr_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      merge_q      <= merge_d;
      addr_q       <= addr_d;
      wb_valid_q   <= wb_valid_d;
      wb_data_q    <= wb_data_d;
      wb_rd_q      <= wb_rd_d;
      fault_q      <= fault_d;
      cause_q      <= cause_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign bus.stall       = stall_c;
  assign bus.dm_wren     = dm_wren_c;
  assign bus.dm_addr     = dm_addr_c;
  assign bus.dm_wdata    = dm_wdata_c;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.fault       = fault_q;
  assign bus.fault_cause = cause_q;
  assign bus.fault_addr  = fault_addr_q;

endmodule
